// File: rtl/hash_pkg.sv
// rtl/hash_pkg.sv - shared types for the hashtable pipeline
package hash_pkg;

  typedef enum logic {
    WB_INIT = 1'b0,
    WB_RUN  = 1'b1
  } wb_state_t;

endpackage

// File: rtl/hash_init_sweeper.sv
// rtl/hash_init_sweeper.sv - memory sweep address counter with terminal-count flag
module hash_init_sweeper #(
  parameter int ADR_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_step,
  output logic [ADR_WIDTH-1:0] o_adr,
  output logic                 o_tc
);

  logic [ADR_WIDTH-1:0] r_cnt;

  // Advance one address per step and wrap to 0 after the last address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_step) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_adr = r_cnt;
  assign o_tc  = &r_cnt;

endmodule

// File: rtl/hash_write_back_stage.sv
// rtl/hash_write_back_stage.sv - hashtable write-back stage and forward bus; HASH_INIT_SWEEP_EN enables the reset sweep
module hash_write_back_stage
  import hash_pkg::*;
#(
  parameter int DATA_WIDTH           = 4,
  parameter int KEY_WIDTH            = 2,
  parameter int HASH_ADR_WIDTH       = 2,
  parameter int SHIFT_HASH_ADR_WIDTH = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clk_en,
  input  logic                            upd_req_i,
  output logic                            upd_ready_o,
  input  logic                            upd_write_i,
  input  logic [HASH_ADR_WIDTH-1:0]       upd_hash_adr_i,
  input  logic [KEY_WIDTH-1:0]            upd_key_i,
  input  logic [DATA_WIDTH-1:0]           upd_data_i,
  input  logic                            upd_valid_i,
  input  logic [SHIFT_HASH_ADR_WIDTH-1:0] upd_shift_adr_i,
  input  logic                            upd_shift_valid_i,
  output logic                            mem_we_o,
  output logic [HASH_ADR_WIDTH-1:0]       mem_adr_o,
  output logic [KEY_WIDTH-1:0]            mem_key_o,
  output logic [DATA_WIDTH-1:0]           mem_data_o,
  output logic                            mem_valid_o,
  output logic [SHIFT_HASH_ADR_WIDTH-1:0] mem_shift_adr_o,
  output logic                            mem_shift_valid_o,
  output logic [HASH_ADR_WIDTH-1:0]       forward_hash_adr_o,
  output logic [KEY_WIDTH-1:0]            forward_key_o,
  output logic [DATA_WIDTH-1:0]           forward_data_o,
  output logic                            forward_valid_o,
  output logic [SHIFT_HASH_ADR_WIDTH-1:0] forward_shift_hash_adr_o,
  output logic                            forward_shift_valid_o,
  output logic                            forward_updated_mem_o,
  output logic                            init_done_o
);

  logic [HASH_ADR_WIDTH-1:0]       r_adr;
  logic [KEY_WIDTH-1:0]            r_key;
  logic [DATA_WIDTH-1:0]           r_data;
  logic                            r_valid;
  logic [SHIFT_HASH_ADR_WIDTH-1:0] r_shift_adr;
  logic                            r_shift_valid;
  logic                            r_we;
  logic                            r_fwd_upd;

  logic                            w_ready;
  logic                            w_accept;
  logic                            w_sweep_step;
  logic [HASH_ADR_WIDTH-1:0]       w_sweep_adr;

`ifdef HASH_INIT_SWEEP_EN
  wb_state_t r_state;
  wb_state_t w_state_nxt;
  logic      r_sweep_last;
  logic      w_sweep_tc;

  hash_init_sweeper #(
    .ADR_WIDTH(HASH_ADR_WIDTH)
  ) u_sweeper (
    .clk    (clk),
    .reset  (reset),
    .i_step (w_sweep_step & clk_en),
    .o_adr  (w_sweep_adr),
    .o_tc   (w_sweep_tc)
  );

  // State register, frozen while the pipeline is stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= WB_INIT;
    end else if (clk_en) begin
      r_state <= w_state_nxt;
    end
  end

  // Sweep while in INIT; move to RUN on the edge that commits the last sweep write
  always_comb begin
    w_state_nxt  = r_state;
    w_sweep_step = 1'b0;
    case (r_state)
      WB_INIT: begin
        if (r_sweep_last) begin
          w_state_nxt = WB_RUN;
        end else begin
          w_sweep_step = 1'b1;
        end
      end
      WB_RUN:  w_state_nxt = WB_RUN;
      default: w_state_nxt = WB_INIT;
    endcase
  end

  // Flag that the terminal address is the one now presented to memory
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sweep_last <= 1'b0;
    end else if (clk_en && w_sweep_step) begin
      r_sweep_last <= w_sweep_tc;
    end
  end

  assign w_ready = (r_state == WB_RUN);
`else
  logic r_ready;

  // No sweep: become ready on the first enabled edge after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready <= 1'b0;
    end else if (clk_en) begin
      r_ready <= 1'b1;
    end
  end

  assign w_ready      = r_ready;
  assign w_sweep_step = 1'b0;
  assign w_sweep_adr  = '0;
`endif

  assign w_accept = upd_req_i & w_ready;

  // Output stage: one sweep write, one accepted request, or an idle cycle with fields held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_adr         <= '0;
      r_key         <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_shift_adr   <= '0;
      r_shift_valid <= 1'b0;
      r_we          <= 1'b0;
      r_fwd_upd     <= 1'b0;
    end else if (clk_en) begin
      if (w_sweep_step) begin
        r_adr         <= w_sweep_adr;
        r_key         <= '0;
        r_data        <= '0;
        r_valid       <= 1'b0;
        r_shift_adr   <= '0;
        r_shift_valid <= 1'b0;
        r_we          <= 1'b1;
        r_fwd_upd     <= 1'b1;
      end else if (w_accept) begin
        r_adr         <= upd_hash_adr_i;
        r_key         <= upd_key_i;
        r_data        <= upd_data_i;
        r_valid       <= upd_valid_i;
        r_shift_adr   <= upd_shift_adr_i;
        r_shift_valid <= upd_shift_valid_i;
        r_we          <= upd_write_i;
        r_fwd_upd     <= upd_write_i;
      end else begin
        r_we          <= 1'b0;
        r_fwd_upd     <= 1'b0;
      end
    end
  end

  // A stalled cycle must not rewrite the held entry
  assign mem_we_o                 = r_we & clk_en;
  assign mem_adr_o                = r_adr;
  assign mem_key_o                = r_key;
  assign mem_data_o               = r_data;
  assign mem_valid_o              = r_valid;
  assign mem_shift_adr_o          = r_shift_adr;
  assign mem_shift_valid_o        = r_shift_valid;
  assign forward_hash_adr_o       = r_adr;
  assign forward_key_o            = r_key;
  assign forward_data_o           = r_data;
  assign forward_valid_o          = r_valid;
  assign forward_shift_hash_adr_o = r_shift_adr;
  assign forward_shift_valid_o    = r_shift_valid;
  assign forward_updated_mem_o    = r_fwd_upd;
  assign upd_ready_o              = w_ready;
  assign init_done_o              = w_ready;

endmodule

// File: tb/tb_hash_write_back_stage.sv
// tb/tb_hash_write_back_stage.sv - scoreboard bench for hash_write_back_stage
module tb_hash_write_back_stage;

  typedef struct packed {
    logic [1:0] adr;
    logic [1:0] key;
    logic [3:0] data;
    logic       valid;
    logic [1:0] sadr;
    logic       svalid;
  } ent_t;

  logic       clk;
  logic       reset;
  logic       clk_en;
  logic       upd_req_i;
  logic       upd_ready_o;
  logic       upd_write_i;
  logic [1:0] upd_hash_adr_i;
  logic [1:0] upd_key_i;
  logic [3:0] upd_data_i;
  logic       upd_valid_i;
  logic [1:0] upd_shift_adr_i;
  logic       upd_shift_valid_i;
  logic       mem_we_o;
  logic [1:0] mem_adr_o;
  logic [1:0] mem_key_o;
  logic [3:0] mem_data_o;
  logic       mem_valid_o;
  logic [1:0] mem_shift_adr_o;
  logic       mem_shift_valid_o;
  logic [1:0] forward_hash_adr_o;
  logic [1:0] forward_key_o;
  logic [3:0] forward_data_o;
  logic       forward_valid_o;
  logic [1:0] forward_shift_hash_adr_o;
  logic       forward_shift_valid_o;
  logic       forward_updated_mem_o;
  logic       init_done_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t exp_q[$];

  hash_write_back_stage #(
    .DATA_WIDTH(4), .KEY_WIDTH(2), .HASH_ADR_WIDTH(2), .SHIFT_HASH_ADR_WIDTH(2)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .clk_en                   (clk_en),
    .upd_req_i                (upd_req_i),
    .upd_ready_o              (upd_ready_o),
    .upd_write_i              (upd_write_i),
    .upd_hash_adr_i           (upd_hash_adr_i),
    .upd_key_i                (upd_key_i),
    .upd_data_i               (upd_data_i),
    .upd_valid_i              (upd_valid_i),
    .upd_shift_adr_i          (upd_shift_adr_i),
    .upd_shift_valid_i        (upd_shift_valid_i),
    .mem_we_o                 (mem_we_o),
    .mem_adr_o                (mem_adr_o),
    .mem_key_o                (mem_key_o),
    .mem_data_o               (mem_data_o),
    .mem_valid_o              (mem_valid_o),
    .mem_shift_adr_o          (mem_shift_adr_o),
    .mem_shift_valid_o        (mem_shift_valid_o),
    .forward_hash_adr_o       (forward_hash_adr_o),
    .forward_key_o            (forward_key_o),
    .forward_data_o           (forward_data_o),
    .forward_valid_o          (forward_valid_o),
    .forward_shift_hash_adr_o (forward_shift_hash_adr_o),
    .forward_shift_valid_o    (forward_shift_valid_o),
    .forward_updated_mem_o    (forward_updated_mem_o),
    .init_done_o              (init_done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; outputs of that edge are then stable
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input logic req, input logic wr, input logic [1:0] adr, input logic [1:0] key,
                         input logic [3:0] data, input logic valid, input logic [1:0] sadr, input logic svalid);
    upd_req_i         = req;
    upd_write_i       = wr;
    upd_hash_adr_i    = adr;
    upd_key_i         = key;
    upd_data_i        = data;
    upd_valid_i       = valid;
    upd_shift_adr_i   = sadr;
    upd_shift_valid_i = svalid;
  endtask

  // Monitor: every presented memory write is matched against the scoreboard
  always @(negedge clk) begin
    if (mem_we_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got adr %0h data %0h expected no write", mem_adr_o, mem_data_o);
      end else begin
        ent_t e;
        ent_t m;
        ent_t f;
        e = exp_q.pop_front();
        m = '{mem_adr_o, mem_key_o, mem_data_o, mem_valid_o, mem_shift_adr_o, mem_shift_valid_o};
        f = '{forward_hash_adr_o, forward_key_o, forward_data_o, forward_valid_o,
              forward_shift_hash_adr_o, forward_shift_valid_o};
        check("sb_mem_entry", 32'(m), 32'(e));
        check("sb_fwd_entry", 32'(f), 32'(e));
        check("sb_fwd_updated", 32'(forward_updated_mem_o), 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    clk_en = 1'b1;
    set_req(0, 0, 2'd0, 2'd0, 4'h0, 0, 2'd0, 0);
    cyc();
    check("rst_ready", 32'(upd_ready_o), 32'd0);
    check("rst_init_done", 32'(init_done_o), 32'd0);
    check("rst_mem_we", 32'(mem_we_o), 32'd0);
    check("rst_fwd_upd", 32'(forward_updated_mem_o), 32'd0);
    check("rst_adr", 32'(mem_adr_o), 32'd0);
    cyc();

`ifdef HASH_INIT_SWEEP_EN
    exp_q.push_back('{2'd0, 2'd0, 4'h0, 1'b0, 2'd0, 1'b0});
    exp_q.push_back('{2'd1, 2'd0, 4'h0, 1'b0, 2'd0, 1'b0});
    reset = 1'b0;
    cyc();
    check("sw_adr0", 32'(mem_adr_o), 32'd0);
    check("sw_we0", 32'(mem_we_o), 32'd1);
    cyc();
    check("sw_adr1", 32'(mem_adr_o), 32'd1);
    clk_en = 1'b0;
    #1;
    check("sw_stall_we", 32'(mem_we_o), 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("sw_stall_adr", 32'(mem_adr_o), 32'd1);
      check("sw_stall_ready", 32'(upd_ready_o), 32'd0);
    end
    clk_en = 1'b1;
    #1;
    check("sw_resume_we", 32'(mem_we_o), 32'd1);
    cyc();
    check("sw_adr2", 32'(mem_adr_o), 32'd2);
    reset = 1'b1;
    #1;
    check("midrst_we", 32'(mem_we_o), 32'd0);
    check("midrst_adr", 32'(mem_adr_o), 32'd0);
    check("midrst_fwd_upd", 32'(forward_updated_mem_o), 32'd0);
    cyc();
    cyc();
    for (int a = 0; a < 4; a++) exp_q.push_back('{2'(a), 2'd0, 4'h0, 1'b0, 2'd0, 1'b0});
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      cyc();
      check("sweep_adr", 32'(mem_adr_o), 32'(a));
      check("sweep_not_done", 32'(init_done_o), 32'd0);
    end
    cyc();
    check("sweep_done", 32'(init_done_o), 32'd1);
    check("sweep_ready", 32'(upd_ready_o), 32'd1);
    check("sweep_end_we", 32'(mem_we_o), 32'd0);
`else
    reset = 1'b0;
    #1;
    check("pre_edge_ready", 32'(upd_ready_o), 32'd0);
    cyc();
    check("run_ready", 32'(upd_ready_o), 32'd1);
    check("run_init_done", 32'(init_done_o), 32'd1);
`endif

    // Single write
    set_req(1, 1, 2'd2, 2'd1, 4'hA, 1, 2'd3, 1);
    exp_q.push_back('{2'd2, 2'd1, 4'hA, 1'b1, 2'd3, 1'b1});
    cyc();
    check("wr_we", 32'(mem_we_o), 32'd1);
    check("wr_fwd_upd", 32'(forward_updated_mem_o), 32'd1);
    upd_req_i = 1'b0;
    cyc();
    check("wr_we_drop", 32'(mem_we_o), 32'd0);
    check("wr_fwd_drop", 32'(forward_updated_mem_o), 32'd0);
    check("wr_hold_data", 32'(mem_data_o), 32'hA);

    // Non-write request
    set_req(1, 0, 2'd1, 2'd2, 4'h5, 1, 2'd0, 0);
    cyc();
    check("nw_we", 32'(mem_we_o), 32'd0);
    check("nw_fwd_upd", 32'(forward_updated_mem_o), 32'd0);
    check("nw_fwd_fields", 32'({forward_hash_adr_o, forward_key_o, forward_data_o, forward_valid_o,
                                forward_shift_hash_adr_o, forward_shift_valid_o}),
          32'({2'd1, 2'd2, 4'h5, 1'b1, 2'd0, 1'b0}));
    upd_req_i = 1'b0;
    cyc();

    // Back-to-back writes to the same address
    set_req(1, 1, 2'd1, 2'd0, 4'h3, 1, 2'd1, 0);
    exp_q.push_back('{2'd1, 2'd0, 4'h3, 1'b1, 2'd1, 1'b0});
    cyc();
    check("b2b_first_we", 32'(mem_we_o), 32'd1);
    check("b2b_first_data", 32'(mem_data_o), 32'h3);
    upd_data_i = 4'h5;
    exp_q.push_back('{2'd1, 2'd0, 4'h5, 1'b1, 2'd1, 1'b0});
    cyc();
    check("b2b_second_we", 32'(mem_we_o), 32'd1);
    check("b2b_second_data", 32'(mem_data_o), 32'h5);
    upd_req_i = 1'b0;
    cyc();
    check("b2b_idle_we", 32'(mem_we_o), 32'd0);

    // Stall right after acceptance
    set_req(1, 1, 2'd3, 2'd3, 4'hF, 1, 2'd2, 1);
    exp_q.push_back('{2'd3, 2'd3, 4'hF, 1'b1, 2'd2, 1'b1});
    cyc();
    clk_en    = 1'b0;
    upd_req_i = 1'b0;
    #1;
    check("stall_we0", 32'(mem_we_o), 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("stall_we", 32'(mem_we_o), 32'd0);
      check("stall_hold_data", 32'(mem_data_o), 32'hF);
    end
    cyc();
    clk_en = 1'b1;
    #1;
    check("stall_release_we", 32'(mem_we_o), 32'd1);
    cyc();
    check("stall_after_we", 32'(mem_we_o), 32'd0);

    cyc();
    cyc();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hash_write_back_stage.md
# hash_write_back_stage

Final stage of the hashtable insert/update pipeline. Accepts one resolved entry update per cycle, writes it into the hashtable memory and drives the forward bus that earlier read stages use to replace stale memory read data. It is the producer end of the forward interface: its forward outputs connect directly to the `forward_*_i` inputs of the forward position updater. After reset it optionally sweeps the whole memory to invalid before accepting traffic.

## Interface
- `DATA_WIDTH`, 4: payload width.
- `KEY_WIDTH`, 2: key width.
- `HASH_ADR_WIDTH`, 2: memory address width; depth = 2^HASH_ADR_WIDTH.
- `SHIFT_HASH_ADR_WIDTH`, 2: width of the shift/alternate hash address.
- `clk  in  1`: single clock.
- `reset  in  1`: asynchronous, active-high.
- `clk_en  in  1`: global stall; when 0, all state holds.
- `upd_req_i  in  1`: update request present.
- `upd_ready_o  out  1`: stage can accept a request.
- `upd_write_i  in  1`: request modifies memory.
- `upd_hash_adr_i  in  HASH_ADR_WIDTH`: target address.
- `upd_key_i  in  KEY_WIDTH`, `upd_data_i  in  DATA_WIDTH`, `upd_valid_i  in  1`: entry contents.
- `upd_shift_adr_i  in  SHIFT_HASH_ADR_WIDTH`, `upd_shift_valid_i  in  1`: entry shift info.
- `mem_we_o  out  1`, `mem_adr_o  out  HASH_ADR_WIDTH`: memory write port.
- `mem_key_o`, `mem_data_o`, `mem_valid_o`, `mem_shift_adr_o`, `mem_shift_valid_o`  out: write data, widths as the matching inputs.
- `forward_hash_adr_o`, `forward_key_o`, `forward_data_o`, `forward_valid_o`, `forward_shift_hash_adr_o`, `forward_shift_valid_o`  out: forward bundle, widths as the matching inputs.
- `forward_updated_mem_o  out  1`: the forward bundle reflects a memory write in this cycle.
- `init_done_o  out  1`: the sweep has finished and the stage is in RUN.

## Operation
- FSM states are INIT and RUN. Reset enters INIT, or RUN when the sweep is compiled out.
- **INIT**
  - A sweep counter runs from 0 to 2^HASH_ADR_WIDTH-1, advancing once per `clk_en` cycle.
  - Each step writes an all-zero entry at the counter address.
  - The forward bus mirrors each sweep write, with `forward_updated_mem_o`=1 and `forward_valid_o`=0.
  - `upd_ready_o`=0 throughout INIT.
- **INIT to RUN:** occurs on the edge that writes the last address. The counter wraps to 0 and is unused afterwards.
- **RUN**
  - `upd_ready_o`=1.
  - A request is accepted on any edge where `upd_req_i && upd_ready_o && clk_en`.
  - Accepted fields are registered into the output stage.
- **Registered outputs for an accepted request**
  - `mem_we_o`=`upd_write_i` and `forward_updated_mem_o`=`upd_write_i`.
  - The mem and forward fields both carry the accepted entry.
- **Cycle with no acceptance (RUN):** `mem_we_o`=0 and `forward_updated_mem_o`=0. The other fields hold their last values.
- **Non-write request (`upd_write_i`=0):** fields still appear on the forward bus, but `forward_updated_mem_o`=0.
- **Back-to-back requests to the same address:** each produces its own write and forward, in acceptance order. There is no merging.
- **`clk_en`=0:** all registers hold. `mem_we_o` is gated to 0 combinationally so held state is never rewritten.
- **Reset asserted mid-sweep or mid-traffic:** immediate asynchronous return to reset values. An in-flight request is dropped and the sweep restarts from address 0.

## Timing
- **Reset values:** every output is 0, including `upd_ready_o`, `init_done_o`, `mem_we_o` and `forward_updated_mem_o`.
- **Latency:** accepted at edge N; write and forward are visible in cycle N+1 and last exactly one cycle.
- **Throughput:** one update per cycle in RUN.
- **Sweep duration:** 2^HASH_ADR_WIDTH enabled cycles. `init_done_o` and `upd_ready_o` rise together, in the cycle after the last sweep write.
- **Forward alignment:** forward and memory write are cycle-aligned. The consumer registers the forward bus to cover the one-cycle read-data hazard.

## Configuration
- **`HASH_INIT_SWEEP_EN` defined:** INIT sweep as above.
- **Macro undefined:**
  - The FSM and counter are removed and the stage resets directly into RUN.
  - `init_done_o` and `upd_ready_o` are 1 from the first cycle after reset deassertion.
  - Memory contents are the responsibility of the memory's own initialisation.

## Structure
- **Shared package `hash_pkg`:** FSM type `wb_state_t` {WB_INIT, WB_RUN}. Add the package if absent.
- **Sub-module `hash_init_sweeper`:** the address counter with a terminal-count flag, instantiated only under `HASH_INIT_SWEEP_EN`.
- All remaining logic stays in this module.

## Test plan
- **Sweep:** reset with the macro on, `HASH_ADR_WIDTH`=2, `clk_en`=1.
  - Four cycles show `mem_we_o`=1 at `mem_adr_o` 0,1,2,3 with `mem_valid_o`=0.
  - `init_done_o`=1 and `upd_ready_o`=1 in the 5th cycle.
- **Single write:** accept adr=2, key=1, data=0xA, valid=1, shift_adr=3, shift_valid=1, write=1.
  - The next cycle shows `mem_we_o`=1 and `forward_updated_mem_o`=1 with identical fields; both are 0 in the following cycle.
- **Non-write request (write=0):** `mem_we_o`=0 and `forward_updated_mem_o`=0, with the forward fields carrying the request.
- **Stall:** hold `clk_en`=0 for 3 cycles right after acceptance.
  - `mem_we_o`=0 throughout the stall; the write appears once `clk_en` returns.
  - During INIT the sweep address freezes.
- **Back-to-back:** adr=1 data=0x3, then adr=1 data=0x5 on consecutive edges. Two consecutive writes occur, the second carrying 0x5.
- **Reset mid-sweep:** assert reset at sweep address 2.
  - Outputs go to 0 immediately.
  - After release, the sweep restarts at address 0.
